uart_cmd_decoder: RTL

Downstream consumer of the UART receiver: takes each received frame (`frame`, `frame_valid`) and assembles sync-framed, checksummed command packets into single-cycle drawing commands for the VGA side (pixel write, screen fill, background colour). Runs in the receiver's clock domain (`clk_16bd` tree). Hands commands downstream with a valid/ready handshake. Reports protocol errors with a pulse and a code.

---
 rtl/uart_cmd_decoder_if.sv | 27 ++
 rtl/uart_cmd_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / command-out bundle between the UART receiver side and the VGA command consumer.
// The decoder takes the master modport; whoever feeds bytes and accepts commands takes slave.
interface uart_cmd_decoder_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [8:0]     frame;
    logic           frame_valid;
    logic           cmd_ready;
    logic           cmd_valid;
    logic [1:0]     cmd_op;
    logic [X_W-1:0] cmd_x;
    logic [Y_W-1:0] cmd_y;
    logic [7:0]     cmd_color;
    logic           err_valid;
    logic [2:0]     err_code;

    modport master (
        input  frame, frame_valid, cmd_ready,
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, err_valid, err_code
    );

    modport slave (
        output frame, frame_valid, cmd_ready,
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, err_valid, err_code
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Assembles sync-framed, XOR-checksummed UART packets into single drawing commands
// with a valid/ready handoff, a one-cycle error pulse and a sticky error code.
module uart_cmd_decoder #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int X_W            = 10,
    parameter int Y_W            = 9,
    parameter int TIMEOUT_CYCLES = 640
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_decoder_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   X_LIM    = 16'(H_ACTIVE);
    localparam logic [15:0]   Y_LIM    = 16'(V_ACTIVE);

    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] OP_PIXEL = 8'h01;
    localparam logic [7:0] OP_FILL  = 8'h02;
    localparam logic [7:0] OP_BG    = 8'h03;

    localparam logic [2:0] ERR_OPCODE  = 3'b001;
    localparam logic [2:0] ERR_CSUM    = 3'b010;
    localparam logic [2:0] ERR_TIMEOUT = 3'b011;
    localparam logic [2:0] ERR_OVERRUN = 3'b100;
    localparam logic [2:0] ERR_RANGE   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_PAYLOAD,
        S_CHECK,
        S_ISSUE
    } state_t;

    state_t        state;
    logic          frame_valid_q;
    logic [1:0]    op_q;
    logic [2:0]    cnt;
    logic [7:0]    csum;
    logic [7:0]    x_hi, x_lo, y_hi, y_lo, color;
    logic [TW-1:0] tmo;

    logic          byte_stb;
    logic [7:0]    byte_val;
    logic [15:0]   x_full, y_full;
    logic          is_pixel;
    logic          out_of_range;

    assign byte_stb     = bus.frame_valid & ~frame_valid_q;
    assign byte_val     = bus.frame[7:0];
    assign x_full       = {x_hi, x_lo};
    assign y_full       = {y_hi, y_lo};
    assign is_pixel     = (op_q == OP_PIXEL[1:0]);
    assign out_of_range = is_pixel && ((x_full >= X_LIM) || (y_full >= Y_LIM));

    // NOTE: every register here is assigned with <= so all reads in this block see
    // the pre-edge values; blocking assignments would make the result order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            frame_valid_q <= 1'b0;
            op_q          <= '0;
            cnt           <= '0;
            csum          <= '0;
            x_hi          <= '0;
            x_lo          <= '0;
            y_hi          <= '0;
            y_lo          <= '0;
            color         <= '0;
            tmo           <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_op    <= '0;
            bus.cmd_x     <= '0;
            bus.cmd_y     <= '0;
            bus.cmd_color <= '0;
            bus.err_valid <= 1'b0;
            bus.err_code  <= '0;
        end else begin
            frame_valid_q <= bus.frame_valid;
            bus.err_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    tmo <= '0;
                    if (byte_stb && byte_val == SYNC)
                        state <= S_OPCODE;
                end

                S_ISSUE: begin
                    tmo <= '0;
                    if (byte_stb) begin
                        bus.err_valid <= 1'b1;
                        bus.err_code  <= ERR_OVERRUN;
                    end
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    // In-packet states: a byte always beats a coincident timeout.
                    if (byte_stb) begin
                        tmo <= '0;
                        case (state)
                            S_OPCODE: begin
                                if (byte_val == OP_PIXEL || byte_val == OP_FILL ||
                                    byte_val == OP_BG) begin
                                    op_q  <= byte_val[1:0];
                                    cnt   <= (byte_val == OP_PIXEL) ? 3'd5 : 3'd1;
                                    csum  <= byte_val;
                                    state <= S_PAYLOAD;
                                end else begin
                                    bus.err_valid <= 1'b1;
                                    bus.err_code  <= ERR_OPCODE;
                                    state         <= S_IDLE;
                                end
                            end

                            S_PAYLOAD: begin
                                case (cnt)
                                    3'd5:    x_hi  <= byte_val;
                                    3'd4:    x_lo  <= byte_val;
                                    3'd3:    y_hi  <= byte_val;
                                    3'd2:    y_lo  <= byte_val;
                                    default: color <= byte_val;
                                endcase
                                csum <= csum ^ byte_val;
                                cnt  <= cnt - 3'd1;
                                if (cnt == 3'd1)
                                    state <= S_CHECK;
                            end

                            default: begin
                                if (byte_val != csum) begin
                                    bus.err_valid <= 1'b1;
                                    bus.err_code  <= ERR_CSUM;
                                    state         <= S_IDLE;
                                end else if (out_of_range) begin
                                    bus.err_valid <= 1'b1;
                                    bus.err_code  <= ERR_RANGE;
                                    state         <= S_IDLE;
                                end else begin
                                    bus.cmd_valid <= 1'b1;
                                    bus.cmd_op    <= op_q;
                                    bus.cmd_x     <= is_pixel ? x_full[X_W-1:0] : '0;
                                    bus.cmd_y     <= is_pixel ? y_full[Y_W-1:0] : '0;
                                    bus.cmd_color <= color;
                                    state         <= S_ISSUE;
                                end
                            end
                        endcase
                    end else if (tmo == TMO_LAST) begin
                        tmo           <= '0;
                        bus.err_valid <= 1'b1;
                        bus.err_code  <= ERR_TIMEOUT;
                        state         <= S_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
